// File: rtl/l2_channel_responder.sv
// ---------------------------------------------------------------------------
// l2_channel_responder
//
// Responder end of one L2 reqrsp channel. Line-wide reads and writes are
// served from an internal word-addressed memory. Each response comes back
// after a fixed latency and in request order, and carries the request's
// user tag unchanged so the crossbar can route it home. A credit counter
// bounds the number of outstanding requests. Because of that bound, the
// response FIFO cannot overflow and the latency pipeline never stalls.
//
// Ports
//   clk_i, rst_i        clock, asynchronous active-high reset
//   req_valid_i/ready_o request handshake
//   req_addr_i          byte address (line-aligned; offset bits ignored)
//   req_write_i         1 = write, 0 = read
//   req_data_i/strb_i   write data and byte enables
//   req_user_i          routing tag, echoed in the response
//   rsp_valid_o/ready_i response handshake
//   rsp_data_o          read data (0 for writes and out-of-range reads)
//   rsp_write_o         echo of req_write_i
//   rsp_error_o         request address was outside the served window
//   rsp_user_o          echo of req_user_i
// ---------------------------------------------------------------------------

package l2_pkg;
  typedef struct packed {
    logic [3:0] bank_id;
    logic [3:0] info;
  } l2_user_t;
endpackage

module l2_channel_responder #(
  parameter int unsigned          DataWidth = 128,
  parameter int unsigned          AddrWidth = 32,
  parameter int unsigned          UserWidth = $bits(l2_pkg::l2_user_t),
  parameter logic [AddrWidth-1:0] BaseAddr  = 32'h8000_0000,
  parameter int unsigned          MemDepth  = 1024,
  parameter int unsigned          Latency   = 2,
  parameter int unsigned          RspDepth  = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  input  logic [AddrWidth-1:0]   req_addr_i,
  input  logic                   req_write_i,
  input  logic [DataWidth-1:0]   req_data_i,
  input  logic [DataWidth/8-1:0] req_strb_i,
  input  logic [UserWidth-1:0]   req_user_i,
  output logic                   rsp_valid_o,
  input  logic                   rsp_ready_i,
  output logic [DataWidth-1:0]   rsp_data_o,
  output logic                   rsp_write_o,
  output logic                   rsp_error_o,
  output logic [UserWidth-1:0]   rsp_user_o
);

  localparam int unsigned StrbWidth = DataWidth / 8;
  localparam int unsigned OffW      = $clog2(StrbWidth);
  localparam int unsigned IdxW      = (MemDepth > 1) ? $clog2(MemDepth) : 1;
  localparam int unsigned CntW      = $clog2(RspDepth + 1);
  localparam int unsigned PtrW      = (RspDepth > 1) ? $clog2(RspDepth) : 1;
  localparam logic [AddrWidth:0] MemBytes = (AddrWidth + 1)'(MemDepth * StrbWidth);

  typedef struct packed {
    logic                 write;
    logic                 error;
    logic [DataWidth-1:0] data;
    logic [UserWidth-1:0] user;
  } rsp_t;

  // -------------------------------------------------------------------------
  // Handshakes and credit counter
  // -------------------------------------------------------------------------
  logic            req_hs;
  logic            rsp_hs;
  logic [CntW-1:0] outst_q;

  assign req_ready_o = (outst_q < CntW'(RspDepth)) && !rst_i;
  assign req_hs      = req_valid_i && req_ready_o;
  assign rsp_hs      = rsp_valid_o && rsp_ready_i;

  // NOTE: state registers use non-blocking assignments so that every flop
  // samples pre-edge values, whatever order the processes happen to run in.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      outst_q <= '0;
    end else begin
      case ({req_hs, rsp_hs})
        2'b10:   outst_q <= outst_q + 1'b1;
        2'b01:   outst_q <= outst_q - 1'b1;
        default: outst_q <= outst_q;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Address decode. The range test is done one bit wider than the address,
  // so a window that ends at the top of the address space cannot wrap.
  // -------------------------------------------------------------------------
  logic [AddrWidth:0] addr_ext;
  logic [AddrWidth:0] base_ext;
  logic               in_range;
  logic [IdxW-1:0]    word_idx;

  assign addr_ext = {1'b0, req_addr_i};
  assign base_ext = {1'b0, BaseAddr};
  assign in_range = (addr_ext >= base_ext) && (addr_ext < base_ext + MemBytes);
  assign word_idx = IdxW'((req_addr_i - BaseAddr) >> OffW);

  // -------------------------------------------------------------------------
  // Storage array
  // -------------------------------------------------------------------------
  logic [DataWidth-1:0] mem_q [MemDepth];
  logic                 mem_we;
  logic [DataWidth-1:0] rd_data;

  assign mem_we  = req_hs && req_write_i && in_range;
  assign rd_data = (in_range && !req_write_i) ? mem_q[word_idx] : '0;

  // NOTE: the array has no reset. Clearing it would need a write port per
  // word or a multi-cycle sweep, and its contents must survive rst_i anyway.
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      for (int b = 0; b < StrbWidth; b++) begin
        if (req_strb_i[b]) mem_q[word_idx][b*8 +: 8] <= req_data_i[b*8 +: 8];
      end
    end
  end

  // -------------------------------------------------------------------------
  // Fixed-latency pipeline. The array is read in the handshake cycle. The
  // result then rides Latency stages, so it reaches the FIFO Latency cycles
  // after the request.
  // -------------------------------------------------------------------------
  rsp_t                       new_rsp;
  logic [Latency-1:0]         pipe_vld_q;
  rsp_t [Latency-1:0]         pipe_q;

  assign new_rsp = '{write: req_write_i, error: !in_range, data: rd_data, user: req_user_i};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pipe_vld_q <= '0;
      pipe_q     <= '0;
    end else begin
      pipe_vld_q[0] <= req_hs;
      if (req_hs) pipe_q[0] <= new_rsp;
      for (int i = 1; i < Latency; i++) begin
        pipe_vld_q[i] <= pipe_vld_q[i-1];
        pipe_q[i]     <= pipe_q[i-1];
      end
    end
  end

  // -------------------------------------------------------------------------
  // Fall-through response FIFO. When the FIFO is empty, the last pipeline
  // stage is presented directly. A beat popped in that same cycle is never
  // stored.
  // -------------------------------------------------------------------------
  rsp_t            fifo_q [RspDepth];
  logic [PtrW-1:0] wr_ptr_q;
  logic [PtrW-1:0] rd_ptr_q;
  logic [CntW-1:0] fifo_cnt_q;
  logic            push;
  logic            fifo_empty;
  logic            fifo_wr;
  logic            fifo_rd;
  rsp_t            head;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(RspDepth - 1)) ? '0 : p + 1'b1;
  endfunction

  assign push       = pipe_vld_q[Latency-1];
  assign fifo_empty = (fifo_cnt_q == '0);
  assign fifo_wr    = push && !(fifo_empty && rsp_hs);
  assign fifo_rd    = rsp_hs && !fifo_empty;

  always_ff @(posedge clk_i) begin
    if (fifo_wr) fifo_q[wr_ptr_q] <= pipe_q[Latency-1];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else begin
      if (fifo_wr) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (fifo_rd) rd_ptr_q <= ptr_inc(rd_ptr_q);
      if (fifo_wr && !fifo_rd)      fifo_cnt_q <= fifo_cnt_q + 1'b1;
      else if (!fifo_wr && fifo_rd) fifo_cnt_q <= fifo_cnt_q - 1'b1;
    end
  end

  // NOTE: head gets a default before any branch, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    head = '0;
    if (!fifo_empty) head = fifo_q[rd_ptr_q];
    else if (push)   head = pipe_q[Latency-1];
  end

  assign rsp_valid_o = !fifo_empty || push;
  assign rsp_data_o  = head.data;
  assign rsp_write_o = head.write;
  assign rsp_error_o = head.error;
  assign rsp_user_o  = head.user;

endmodule

// File: tb/tb_l2_channel_responder.sv
// ---------------------------------------------------------------------------
// Directed testbench for l2_channel_responder (default geometry: 128-bit
// lines, 1024 words at 0x8000_0000, Latency 2, RspDepth 4). Inputs change
// 1 time unit after the rising edge. Outputs are sampled on the falling
// edge, and handshakes are logged there with the cycle number.
// ---------------------------------------------------------------------------
module tb_l2_channel_responder;

  localparam int DW    = 128;
  localparam int AW    = 32;
  localparam int UW    = 8;
  localparam int LAT   = 2;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [AW-1:0] req_addr = '0;
  logic          req_write = 1'b0;
  logic [DW-1:0] req_data = '0;
  logic [15:0]   req_strb = '0;
  logic [UW-1:0] req_user = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [DW-1:0] rsp_data;
  logic          rsp_write;
  logic          rsp_error;
  logic [UW-1:0] rsp_user;

  l2_channel_responder #(
    .DataWidth (DW),
    .AddrWidth (AW),
    .UserWidth (UW),
    .BaseAddr  (32'h8000_0000),
    .MemDepth  (1024),
    .Latency   (LAT),
    .RspDepth  (DEPTH)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_addr_i  (req_addr),
    .req_write_i (req_write),
    .req_data_i  (req_data),
    .req_strb_i  (req_strb),
    .req_user_i  (req_user),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_data_o  (rsp_data),
    .rsp_write_o (rsp_write),
    .rsp_error_o (rsp_error),
    .rsp_user_o  (rsp_user)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int            cyc;
    logic [DW-1:0] data;
    logic          write;
    logic          error;
    logic [UW-1:0] user;
  } rsp_rec_t;

  rsp_rec_t rsp_q[$];
  int       acc_q[$];
  rsp_rec_t mon_r;

  always @(negedge clk) begin
    if (!rst) begin
      if (req_valid && req_ready) acc_q.push_back(cyc);
      if (rsp_valid && rsp_ready) begin
        mon_r.cyc   = cyc;
        mon_r.data  = rsp_data;
        mon_r.write = rsp_write;
        mon_r.error = rsp_error;
        mon_r.user  = rsp_user;
        rsp_q.push_back(mon_r);
      end
    end
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called at posedge+1. Holds the request until it is accepted, then
  // returns at posedge+1 of the cycle after the acceptance.
  task automatic send(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                      input logic [15:0] strb, input logic [UW-1:0] user);
    int n;
    n = 0;
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_data  = data;
    req_strb  = strb;
    req_user  = user;
    @(negedge clk);
    while (!req_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (n == 50) check("send_timeout", {127'b0, req_ready}, 1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input string tag, input int n);
    int k;
    k = 0;
    while (rsp_q.size() < n && k < 200) begin
      @(posedge clk);
      k++;
    end
    check(tag, rsp_q.size(), n);
    #1;
  endtask

  task automatic clear_logs();
    rsp_q.delete();
    acc_q.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog timeout");
  end

  localparam logic [DW-1:0] K1 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
  localparam logic [DW-1:0] K2 = 128'hDEAD_BEEF_0000_1111_2222_3333_CAFE_F00D;

  int accepted;

  initial begin
    // ---------------- reset values ----------------
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", {127'b0, req_ready}, 0);
    check("rst_rsp_valid", {127'b0, rsp_valid}, 0);
    check("rst_rsp_data",  rsp_data, 0);
    check("rst_rsp_write", {127'b0, rsp_write}, 0);
    check("rst_rsp_error", {127'b0, rsp_error}, 0);
    check("rst_rsp_user",  {120'b0, rsp_user}, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", {127'b0, req_ready}, 1);
    check("valid_after_rst", {127'b0, rsp_valid}, 0);
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;

    // ---------------- write then read ----------------
    clear_logs();
    send(1'b1, 32'h8000_0040, {16{8'hA5}}, 16'hFFFF, 8'h03);
    send(1'b0, 32'h8000_0040, '0, 16'h0000, 8'h07);
    wait_rsp("t1_count", 2);
    check("t1_w_write", {127'b0, rsp_q[0].write}, 1);
    check("t1_w_data",  rsp_q[0].data, 0);
    check("t1_w_error", {127'b0, rsp_q[0].error}, 0);
    check("t1_w_user",  {120'b0, rsp_q[0].user}, 8'h03);
    check("t1_w_lat",   rsp_q[0].cyc - acc_q[0], LAT);
    check("t1_r_write", {127'b0, rsp_q[1].write}, 0);
    check("t1_r_data",  rsp_q[1].data, {16{8'hA5}});
    check("t1_r_user",  {120'b0, rsp_q[1].user}, 8'h07);
    check("t1_r_lat",   rsp_q[1].cyc - acc_q[1], LAT);
    check("t1_r_gap",   rsp_q[1].cyc - rsp_q[0].cyc, 1);

    // ---------------- partial strobe ----------------
    clear_logs();
    send(1'b1, 32'h8000_0100, {DW{1'b1}}, 16'hFFFF, 8'h10);
    send(1'b1, 32'h8000_0100, '0, 16'h000F, 8'h11);
    send(1'b0, 32'h8000_0100, '0, 16'h0000, 8'h12);
    wait_rsp("t2_count", 3);
    check("t2_w1_data", rsp_q[1].data, 0);
    check("t2_r_data",  rsp_q[2].data, {{96{1'b1}}, 32'h0});
    check("t2_r_user",  {120'b0, rsp_q[2].user}, 8'h12);

    // ---------------- streaming ----------------
    clear_logs();
    for (int i = 0; i < 16; i++) send(1'b0, 32'h8000_0000 + 32'(i * 16), '0, 16'h0000, 8'(i));
    wait_rsp("t3_count", 16);
    check("t3_first_lat", rsp_q[0].cyc - acc_q[0], LAT);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("t3_acc_%0d", i),  acc_q[i] - acc_q[0], i);
      check($sformatf("t3_rcyc_%0d", i), rsp_q[i].cyc - rsp_q[0].cyc, i);
      check($sformatf("t3_user_%0d", i), {120'b0, rsp_q[i].user}, i);
    end

    // ---------------- backpressure ----------------
    clear_logs();
    accepted  = 0;
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 32'h8000_0040;
    for (int j = 0; j < 14; j++) begin
      req_user  = 8'(8'h20 + accepted);
      rsp_ready = (j == 8);
      @(negedge clk);
      if (j == 7) begin
        check("bp_accepted_4",   accepted, DEPTH);
        check("bp_ready_low",    {127'b0, req_ready}, 0);
        check("bp_hold_valid",   {127'b0, rsp_valid}, 1);
        check("bp_hold_user",    {120'b0, rsp_user}, 8'h20);
      end
      if (j == 8) check("bp_ready_same_cycle", {127'b0, req_ready}, 0);
      if (j == 9) begin
        check("bp_ready_next_cycle", {127'b0, req_ready}, 1);
        check("bp_next_head_user",   {120'b0, rsp_user}, 8'h21);
      end
      if (req_valid && req_ready) accepted++;
      @(posedge clk);
      #1;
    end
    check("bp_accepted_5", accepted, DEPTH + 1);
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    wait_rsp("bp_count", 5);
    for (int i = 0; i < 5; i++) check($sformatf("bp_user_%0d", i), {120'b0, rsp_q[i].user}, 8'h20 + i);

    // ---------------- out of range ----------------
    clear_logs();
    send(1'b1, 32'h8000_0000, K1, 16'hFFFF, 8'h30);
    send(1'b0, 32'h7FFF_FFF0, '0, 16'h0000, 8'h31);
    send(1'b1, 32'h8000_4000, ~K1, 16'hFFFF, 8'h32);
    send(1'b0, 32'h8000_0000, '0, 16'h0000, 8'h33);
    send(1'b1, 32'h8000_3FF0, K2, 16'hFFFF, 8'h34);
    send(1'b0, 32'h8000_3FFC, '0, 16'h0000, 8'h35);
    wait_rsp("oor_count", 6);
    check("oor_inrange_err", {127'b0, rsp_q[0].error}, 0);
    check("oor_rd_err",      {127'b0, rsp_q[1].error}, 1);
    check("oor_rd_data",     rsp_q[1].data, 0);
    check("oor_rd_user",     {120'b0, rsp_q[1].user}, 8'h31);
    check("oor_wr_err",      {127'b0, rsp_q[2].error}, 1);
    check("oor_wr_write",    {127'b0, rsp_q[2].write}, 1);
    check("oor_base_err",    {127'b0, rsp_q[3].error}, 0);
    check("oor_base_kept",   rsp_q[3].data, K1);
    check("oor_last_err",    {127'b0, rsp_q[5].error}, 0);
    check("oor_last_data",   rsp_q[5].data, K2);

    // ---------------- reset mid-flight ----------------
    clear_logs();
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(1'b0, 32'h8000_0040, '0, 16'h0000, 8'(8'h40 + i));
    @(negedge clk);
    check("mf_pre_valid", {127'b0, rsp_valid}, 1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    for (int j = 0; j < 2; j++) begin
      @(negedge clk);
      check($sformatf("mf_rst_valid_%0d", j), {127'b0, rsp_valid}, 0);
      check($sformatf("mf_rst_ready_%0d", j), {127'b0, req_ready}, 0);
      @(posedge clk);
      #1;
    end
    rst       = 1'b0;
    rsp_ready = 1'b1;
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      if (j == 0) check("mf_ready_after", {127'b0, req_ready}, 1);
      check($sformatf("mf_post_valid_%0d", j), {127'b0, rsp_valid}, 0);
      @(posedge clk);
      #1;
    end
    check("mf_no_stale", rsp_q.size(), 0);
    send(1'b0, 32'h8000_0040, '0, 16'h0000, 8'h50);
    wait_rsp("mf_count", 1);
    check("mf_mem_kept", rsp_q[0].data, {16{8'hA5}});
    check("mf_user",     {120'b0, rsp_q[0].user}, 8'h50);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
